// File: rtl/crypt_result_fifo.sv
// Result FIFO between the modexp core and the narrow output path.
// Stores whole words and streams each one out LSB chunk first.
module crypt_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OUT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     clear,
  input  logic                     load,
  input  logic [WIDTH-1:0]         R_i,
  output logic [OUT_W-1:0]         C_ex,
  output logic                     C_valid,
  input  logic                     C_ready,
  output logic                     C_last,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int NCHUNK = WIDTH / OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW = AW + 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             pop, retire, push, drop;
  logic             is_last;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] shifted;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign overflow = ovf_q;
  assign C_valid = !empty;
  assign is_last = (idx_q == LAST);
  assign C_last  = C_valid & is_last;

  assign head    = mem_q[rptr_q];
  assign shifted = head >> (int'(idx_q) * OUT_W);
  assign C_ex    = C_valid ? shifted[OUT_W-1:0] : '0;

  assign pop    = ena & C_valid & C_ready;
  assign retire = pop & is_last;
  assign push   = load & (!full | retire);
  assign drop   = load & full & !retire;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      idx_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (retire) begin
        idx_d  = '0;
        rptr_d = rptr_q + AW'(1);
      end else if (pop) begin
        idx_d = idx_q + IW'(1);
      end
      unique case ({push, retire})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (drop) ovf_d = 1'b1;
    end
  end

  // ena gates every register, so a disabled cycle changes nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (ena) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ena & !clear & push) mem_q[wptr_q] <= R_i;
  end

endmodule

// File: tb/tb_crypt_result_fifo.sv
// Directed bench for crypt_result_fifo with an expected-chunk queue.
// A second instance covers the single-chunk configuration.
module tb_crypt_result_fifo;

  logic       clk = 0;
  logic       rst = 0;
  logic       ena = 0;
  logic       clear = 0;
  logic       load = 0;
  logic [7:0] R = '0;
  logic       rdy = 0;

  logic [3:0] c_ex;
  logic       c_valid, c_last, full, empty, ovf;
  logic [2:0] cnt;

  logic [7:0] c_ex2;
  logic       c_valid2, c_last2, full2, empty2, ovf2;
  logic [2:0] cnt2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] chunk;
    logic       last;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  crypt_result_fifo #(.WIDTH(8), .DEPTH(4), .OUT_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .load(load),
    .R_i(R), .C_ex(c_ex), .C_valid(c_valid), .C_ready(rdy),
    .C_last(c_last), .full(full), .empty(empty), .count(cnt),
    .overflow(ovf)
  );

  crypt_result_fifo #(.WIDTH(8), .DEPTH(4), .OUT_W(8)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .load(load),
    .R_i(R), .C_ex(c_ex2), .C_valid(c_valid2), .C_ready(rdy),
    .C_last(c_last2), .full(full2), .empty(empty2), .count(cnt2),
    .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    sb.push_back('{chunk: w[3:0], last: 1'b0});
    sb.push_back('{chunk: w[7:4], last: 1'b1});
  endtask

  task automatic expect_chunk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed chunk %0h expected none", tag, c_ex);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(c_valid), 32'd1);
      check({tag, "_ex"}, 32'(c_ex), 32'(e.chunk));
      check({tag, "_last"}, 32'(c_last), 32'(e.last));
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      expect_chunk(tag);
      step();
    end
    check({tag, "_done"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // reset state
    rst = 1;
    #2;
    check("rst_valid", 32'(c_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    step();
    rst = 0;
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ex", 32'(c_ex), 32'd0);
    check("rst_last", 32'(c_last), 32'd0);

    // single word
    ena = 1; rdy = 1; load = 1; R = 8'hA5;
    push_word(8'hA5);
    step();
    load = 0;
    expect_chunk("s1_c0");
    step();
    expect_chunk("s1_c1");
    step();
    check("s1_empty", 32'(empty), 32'd1);
    check("s1_cnt", 32'(cnt), 32'd0);

    // fill and overflow
    rdy = 0; load = 1;
    R = 8'h11; push_word(R); step();
    R = 8'h22; push_word(R); step();
    R = 8'h33; push_word(R); step();
    R = 8'h44; push_word(R); step();
    check("s2_full", 32'(full), 32'd1);
    check("s2_cnt4", 32'(cnt), 32'd4);
    check("s2_ovf0", 32'(ovf), 32'd0);
    R = 8'h55; step();
    load = 0;
    check("s2_ovf1", 32'(ovf), 32'd1);
    check("s2_cnt", 32'(cnt), 32'd4);
    rdy = 1;
    drain("s2_drain");
    check("s2_empty", 32'(empty), 32'd1);
    check("s2_ovf_hold", 32'(ovf), 32'd1);

    // full with push and retire together
    rdy = 0; load = 1;
    R = 8'h78; push_word(R); step();
    R = 8'h9A; push_word(R); step();
    R = 8'hBC; push_word(R); step();
    R = 8'hDE; push_word(R); step();
    load = 0; rdy = 1;
    expect_chunk("s3_h0");
    step();
    expect_chunk("s3_h1");
    load = 1; R = 8'h66; push_word(R);
    step();
    load = 0;
    check("s3_cnt", 32'(cnt), 32'd4);
    check("s3_full", 32'(full), 32'd1);
    check("s3_ovf", 32'(ovf), 32'd1);
    drain("s3_drain");
    check("s3_empty", 32'(empty), 32'd1);

    // ena freeze mid-word
    rdy = 0; load = 1;
    R = 8'h3C; push_word(R); step();
    R = 8'h5F; push_word(R); step();
    load = 0; rdy = 1;
    expect_chunk("s4_c0");
    step();
    ena = 0; load = 1; R = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s4_frz_ex", 32'(c_ex), 32'h3);
      check("s4_frz_last", 32'(c_last), 32'd1);
      check("s4_frz_cnt", 32'(cnt), 32'd2);
    end
    ena = 1; load = 0;
    drain("s4_drain");
    check("s4_empty", 32'(empty), 32'd1);

    // clear beats load and pop
    rdy = 0; load = 1;
    R = 8'h12; step();
    R = 8'h34; step();
    check("s5_cnt2", 32'(cnt), 32'd2);
    clear = 1; load = 1; R = 8'h99; rdy = 1;
    step();
    clear = 0; load = 0;
    check("s5_empty", 32'(empty), 32'd1);
    check("s5_cnt", 32'(cnt), 32'd0);
    check("s5_ovf", 32'(ovf), 32'd0);
    check("s5_ex", 32'(c_ex), 32'd0);
    step();
    check("s5_discard", 32'(c_valid), 32'd0);

    // async reset between edges
    rdy = 0; load = 1; R = 8'h21;
    step();
    load = 0;
    check("s6_valid", 32'(c_valid), 32'd1);
    #2;
    rst = 1;
    #1;
    check("s6_valid0", 32'(c_valid), 32'd0);
    check("s6_ex0", 32'(c_ex), 32'd0);
    check("s6_cnt0", 32'(cnt), 32'd0);
    check("s6_empty", 32'(empty), 32'd1);
    step();
    rst = 0;

    // one chunk per word
    rdy = 1; load = 1; R = 8'hA5;
    step();
    load = 0;
    check("n1_valid", 32'(c_valid2), 32'd1);
    check("n1_ex", 32'(c_ex2), 32'hA5);
    check("n1_last", 32'(c_last2), 32'd1);
    step();
    check("n1_empty", 32'(empty2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crypt_result_fifo.md
Name: crypt_result_fifo

Overview:
- Parametrised successor to the single-word ciphertext result register.
- Buffers up to DEPTH WIDTH-bit crypt results and streams each one out as WIDTH/OUT_W chunks, LSB chunk first, over a valid/ready handshake.
- Sits between the modular-exponentiation core and the narrow output/SPI path.
- The core can deposit results back-to-back while the output side drains them at its own pace.

Parameters:
- WIDTH, 8: bit width of one crypt result.
- DEPTH, 4: number of result entries. Must be a power of 2, ≥ 2.
- OUT_W, 4: output chunk width. WIDTH must be an integer multiple of OUT_W. NCHUNK = WIDTH/OUT_W.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ena  input  1  global enable. When 0, all state is frozen.
- clear  input  1  synchronous flush, active-high. Qualified by ena.
- load  input  1  push R_i into the FIFO. Qualified by ena.
- R_i  input  WIDTH  result word to store.
- C_ex  output  OUT_W  current output chunk.
- C_valid  output  1  C_ex holds a valid chunk.
- C_ready  input  1  downstream accepts the chunk.
- C_last  output  1  current chunk is the final chunk of its word.
- full  output  1  DEPTH entries stored.
- empty  output  1  no entries stored.
- count  output  $clog2(DEPTH)+1  number of stored entries, including a partially sent head.
- overflow  output  1  sticky: a load was dropped.

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - write ptr, read ptr, chunk index and count = 0
  - empty=1, full=0, overflow=0, C_valid=0, C_last=0, C_ex=0
  - Storage contents are don't-care.
- Releasing reset mid-stream loses all entries. No partial word survives.
- ena=0: no pointer, count, index, flag or storage change. Outputs hold. Handshakes are not counted even if C_valid&C_ready.
- Pop event: ena & C_valid & C_ready.
- Retire event: pop & (idx == NCHUNK-1).
- Priority when ena=1: clear > (push, pop).
- clear=1:
  - pointers, idx and count go to 0; overflow goes to 0.
  - Any load or pop in the same cycle is ignored.
- push = load & (!full | retire).
  - Writes R_i at the write pointer and advances the pointer modulo DEPTH.
  - Push while full is allowed only when the head retires in the same cycle; count stays DEPTH.
- load & full & !retire: word is dropped, overflow is set to 1, and nothing else changes.
- Each pop advances idx by 1. On retire, idx returns to 0, the read pointer advances modulo DEPTH, and count decrements.
- Same-cycle push and retire: count is unchanged.
- Outputs are combinational from registered state:
  - C_valid = !empty.
  - C_ex = head[idx*OUT_W +: OUT_W] when C_valid, else 0.
  - C_last = C_valid & (idx == NCHUNK-1).
  - empty = (count == 0); full = (count == DEPTH).
- Latency: a word pushed at edge k into an empty FIFO presents chunk 0 on C_ex after edge k (next cycle). Minimum write-to-first-chunk latency is 1 cycle.
- C_valid is never deasserted while a chunk is unaccepted, except by clear or rst.
- C_ex is stable while C_valid & !C_ready.
- NCHUNK=1 (OUT_W=WIDTH): every pop is a retire, and C_last = C_valid.
- Pointers wrap silently; full/empty are derived from count only.

Test Plan:
1. Reset and single word (defaults):
   - Stimulus: rst pulse, then load R_i=0xA5 with ena=1 and C_ready=1.
   - Response: next cycle C_valid=1, C_ex=0x5, C_last=0; following cycle C_ex=0xA, C_last=1; then empty=1, count=0.
2. Fill and overflow:
   - Stimulus: C_ready=0; load 0x11, 0x22, 0x33, 0x44, 0x55.
   - Response: full=1 and count=4 after the 4th load; 5th dropped, overflow=1.
   - Drain yields chunks 1,1,2,2,3,3,4,4 in order; overflow stays 1 until clear.
3. Full with simultaneous push/retire:
   - Stimulus: full FIFO, head on its last chunk, C_ready=1 and load 0x66 in the same cycle.
   - Response: count stays 4, overflow unchanged, 0x66 emerges last.
4. ena freeze:
   - Stimulus: mid-word (idx=1), drop ena for 3 cycles while C_ready=1 and load=1.
   - Response: C_ex, count and idx unchanged and no push occurs; streaming resumes at the same chunk when ena=1.
5. Clear priority:
   - Stimulus: 2 entries queued, clear=1 with load=1 and C_ready=1 in the same cycle.
   - Response: empty=1, count=0, overflow=0, C_ex=0; the loaded word is discarded.
6. Async reset mid-stream:
   - Stimulus: assert rst between clock edges while C_valid=1.
   - Response: outputs go to their reset values immediately, without waiting for clk.
   - Also repeat scenario 1 with WIDTH=OUT_W=8: one chunk per word with C_last=1.
